// File: rtl/ram512_arbiter_pkg.sv
// Shared types and defaults for the two-client ram512 arbiter.
// State and owner encodings are fixed so waveforms and other blocks can decode them.
package ram512_arbiter_pkg;

    localparam int unsigned ADDR_W_DEF = 9;
    localparam int unsigned DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    typedef enum logic {
        OWN_A = 1'b0,
        OWN_B = 1'b1
    } owner_e;

    // Client that gets priority after the given client has been served.
    function automatic owner_e other_owner(input owner_e o);
        return (o == OWN_A) ? OWN_B : OWN_A;
    endfunction

endpackage

// File: rtl/ram512_arbiter_rr.sv
// Two-input round-robin arbiter: one-hot grant (bit 0 = A, bit 1 = B) from the
// request pair and a pointer that moves past the winner on each accept.
module rr_arbiter2
    import ram512_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant_c
);

    owner_e ptr_q;
    owner_e ptr_d;

    // ptr_q names the client that wins a tie.
    always_comb begin
        grant_c = 2'b00;
        case (req)
            2'b01:   grant_c = 2'b01;
            2'b10:   grant_c = 2'b10;
            2'b11:   grant_c = (ptr_q == OWN_A) ? 2'b01 : 2'b10;
            default: grant_c = 2'b00;
        endcase
    end

    always_comb begin
        ptr_d = ptr_q;
        if (accept && (grant_c != 2'b00)) begin
            ptr_d = other_owner(grant_c[0] ? OWN_A : OWN_B);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= OWN_A;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/ram512_arbiter.sv
// Shares one ram512 between clients A and B: round-robin grant in IDLE, then a
// single in-flight ISSUE/WAIT/RESP sequence with a one-cycle response pulse.
module ram512_arbiter
    import ram512_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              a_req_valid,
    output logic              a_req_ready,
    input  logic              a_req_we,
    input  logic [ADDR_W-1:0] a_req_addr,
    input  logic [DATA_W-1:0] a_req_wdata,
    output logic              a_rsp_valid,
    output logic [DATA_W-1:0] a_rsp_rdata,

    input  logic              b_req_valid,
    output logic              b_req_ready,
    input  logic              b_req_we,
    input  logic [ADDR_W-1:0] b_req_addr,
    input  logic [DATA_W-1:0] b_req_wdata,
    output logic              b_rsp_valid,
    output logic [DATA_W-1:0] b_rsp_rdata,

    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data_in,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_data_out,

    output logic              busy
);

    generate
        if (RD_LATENCY > 1) begin : g_bad_rd_latency
            $error("ram512_arbiter: RD_LATENCY must be 0 or 1");
        end
    endgenerate

    localparam bit ASYNC_RD = (RD_LATENCY == 0);

    state_e            state_q,       state_d;
    owner_e            owner_q,       owner_d;
    logic              we_q,          we_d;
    logic [ADDR_W-1:0] ram_addr_q,    ram_addr_d;
    logic [DATA_W-1:0] ram_data_in_q, ram_data_in_d;
    logic              ram_we_q,      ram_we_d;
    logic              a_rsp_valid_q, a_rsp_valid_d;
    logic [DATA_W-1:0] a_rsp_rdata_q, a_rsp_rdata_d;
    logic              b_rsp_valid_q, b_rsp_valid_d;
    logic [DATA_W-1:0] b_rsp_rdata_q, b_rsp_rdata_d;
    logic              busy_q,        busy_d;

    logic [1:0]        grant_c;
    logic              hs_a_c;
    logic              hs_b_c;
    logic              capture_c;
    logic [DATA_W-1:0] resp_data_c;

    rr_arbiter2 u_rr (
        .clk     (clk),
        .reset   (reset),
        .req     ({b_req_valid, a_req_valid}),
        .accept  (hs_a_c | hs_b_c),
        .grant_c (grant_c)
    );

    assign a_req_ready = (state_q == ST_IDLE) & grant_c[0];
    assign b_req_ready = (state_q == ST_IDLE) & grant_c[1];
    assign hs_a_c      = a_req_valid & a_req_ready;
    assign hs_b_c      = b_req_valid & b_req_ready;

    // Next-state, request latch and response capture.
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        we_d          = we_q;
        ram_addr_d    = ram_addr_q;
        ram_data_in_d = ram_data_in_q;
        ram_we_d      = 1'b0;
        a_rsp_valid_d = 1'b0;
        a_rsp_rdata_d = a_rsp_rdata_q;
        b_rsp_valid_d = 1'b0;
        b_rsp_rdata_d = b_rsp_rdata_q;
        capture_c     = 1'b0;
        resp_data_c   = '0;

        case (state_q)
            ST_IDLE: begin
                if (hs_a_c) begin
                    owner_d       = OWN_A;
                    we_d          = a_req_we;
                    ram_addr_d    = a_req_addr;
                    ram_data_in_d = a_req_wdata;
                    ram_we_d      = a_req_we;
                    state_d       = ST_ISSUE;
                end else if (hs_b_c) begin
                    owner_d       = OWN_B;
                    we_d          = b_req_we;
                    ram_addr_d    = b_req_addr;
                    ram_data_in_d = b_req_wdata;
                    ram_we_d      = b_req_we;
                    state_d       = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (we_q || ASYNC_RD) begin
                    capture_c = 1'b1;
                    state_d   = ST_RESP;
                end else begin
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                capture_c = 1'b1;
                state_d   = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The response registers load on entry to RESP, so the pulse lines up with RESP.
        if (capture_c) begin
            resp_data_c = we_q ? '0 : ram_data_out;
            if (owner_q == OWN_A) begin
                a_rsp_valid_d = 1'b1;
                a_rsp_rdata_d = resp_data_c;
            end else begin
                b_rsp_valid_d = 1'b1;
                b_rsp_rdata_d = resp_data_c;
            end
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            owner_q       <= OWN_A;
            we_q          <= 1'b0;
            ram_addr_q    <= '0;
            ram_data_in_q <= '0;
            ram_we_q      <= 1'b0;
            a_rsp_valid_q <= 1'b0;
            a_rsp_rdata_q <= '0;
            b_rsp_valid_q <= 1'b0;
            b_rsp_rdata_q <= '0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            we_q          <= we_d;
            ram_addr_q    <= ram_addr_d;
            ram_data_in_q <= ram_data_in_d;
            ram_we_q      <= ram_we_d;
            a_rsp_valid_q <= a_rsp_valid_d;
            a_rsp_rdata_q <= a_rsp_rdata_d;
            b_rsp_valid_q <= b_rsp_valid_d;
            b_rsp_rdata_q <= b_rsp_rdata_d;
            busy_q        <= busy_d;
        end
    end

    assign ram_addr    = ram_addr_q;
    assign ram_data_in = ram_data_in_q;
    assign ram_we      = ram_we_q;
    assign a_rsp_valid = a_rsp_valid_q;
    assign a_rsp_rdata = a_rsp_rdata_q;
    assign b_rsp_valid = b_rsp_valid_q;
    assign b_rsp_rdata = b_rsp_rdata_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_ram512_arbiter.sv
// Bench for ram512_arbiter: one RD_LATENCY=1 instance and one RD_LATENCY=0
// instance, each with a behavioural 512x16 RAM behind it.
module tb_ram512_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;

    logic        a_req_valid, a_req_ready, a_req_we, a_rsp_valid;
    logic [8:0]  a_req_addr;
    logic [15:0] a_req_wdata, a_rsp_rdata;
    logic        b_req_valid, b_req_ready, b_req_we, b_rsp_valid;
    logic [8:0]  b_req_addr;
    logic [15:0] b_req_wdata, b_rsp_rdata;
    logic [8:0]  ram_addr;
    logic [15:0] ram_data_in, ram_data_out;
    logic        ram_we, busy;

    logic        l0_a_req_valid, l0_a_req_ready, l0_a_req_we, l0_a_rsp_valid;
    logic [8:0]  l0_a_req_addr;
    logic [15:0] l0_a_req_wdata, l0_a_rsp_rdata;
    logic        l0_b_req_valid, l0_b_req_ready, l0_b_req_we, l0_b_rsp_valid;
    logic [8:0]  l0_b_req_addr;
    logic [15:0] l0_b_req_wdata, l0_b_rsp_rdata;
    logic [8:0]  l0_ram_addr;
    logic [15:0] l0_ram_data_in, l0_ram_data_out;
    logic        l0_ram_we, l0_busy;

    ram512_arbiter #(.ADDR_W(9), .DATA_W(16), .RD_LATENCY(1)) dut (
        .clk(clk), .reset(reset),
        .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_we(a_req_we),
        .a_req_addr(a_req_addr), .a_req_wdata(a_req_wdata),
        .a_rsp_valid(a_rsp_valid), .a_rsp_rdata(a_rsp_rdata),
        .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_we(b_req_we),
        .b_req_addr(b_req_addr), .b_req_wdata(b_req_wdata),
        .b_rsp_valid(b_rsp_valid), .b_rsp_rdata(b_rsp_rdata),
        .ram_addr(ram_addr), .ram_data_in(ram_data_in), .ram_we(ram_we),
        .ram_data_out(ram_data_out), .busy(busy)
    );

    ram512_arbiter #(.ADDR_W(9), .DATA_W(16), .RD_LATENCY(0)) dut0 (
        .clk(clk), .reset(reset),
        .a_req_valid(l0_a_req_valid), .a_req_ready(l0_a_req_ready), .a_req_we(l0_a_req_we),
        .a_req_addr(l0_a_req_addr), .a_req_wdata(l0_a_req_wdata),
        .a_rsp_valid(l0_a_rsp_valid), .a_rsp_rdata(l0_a_rsp_rdata),
        .b_req_valid(l0_b_req_valid), .b_req_ready(l0_b_req_ready), .b_req_we(l0_b_req_we),
        .b_req_addr(l0_b_req_addr), .b_req_wdata(l0_b_req_wdata),
        .b_rsp_valid(l0_b_rsp_valid), .b_rsp_rdata(l0_b_rsp_rdata),
        .ram_addr(l0_ram_addr), .ram_data_in(l0_ram_data_in), .ram_we(l0_ram_we),
        .ram_data_out(l0_ram_data_out), .busy(l0_busy)
    );

    // Registered-read RAM for dut, asynchronous-read RAM for dut0.
    logic [15:0] mem1 [512];
    logic [15:0] mem0 [512];
    logic [15:0] rd1;

    initial begin
        for (int i = 0; i < 512; i++) begin
            mem1[i] = 16'h0000;
            mem0[i] = 16'h0000;
        end
        rd1 = 16'h0000;
    end

    always @(posedge clk) begin
        if (ram_we) mem1[ram_addr] <= ram_data_in;
        rd1 <= mem1[ram_addr];
        if (l0_ram_we) mem0[l0_ram_addr] <= l0_ram_data_in;
    end

    assign ram_data_out    = rd1;
    assign l0_ram_data_out = mem0[l0_ram_addr];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk_bit(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_word(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    // One transaction on dut from IDLE; returns at +1ns of the IDLE cycle after RESP.
    task automatic txn(input logic cli, input logic we, input logic [8:0] addr,
                       input logic [15:0] wdata, input logic [15:0] exp);
        int kexp;
        kexp = we ? 2 : 3;
        if (!cli) begin
            a_req_valid = 1'b1; a_req_we = we; a_req_addr = addr; a_req_wdata = wdata;
        end else begin
            b_req_valid = 1'b1; b_req_we = we; b_req_addr = addr; b_req_wdata = wdata;
        end
        #1;
        chk_bit("txn_ready", cli ? b_req_ready : a_req_ready, 1'b1);
        chk_bit("txn_other_ready", cli ? a_req_ready : b_req_ready, 1'b0);
        step();
        a_req_valid = 1'b0;
        b_req_valid = 1'b0;
        for (int k = 1; k <= kexp + 1; k++) begin
            chk_bit("txn_own_rsp", cli ? b_rsp_valid : a_rsp_valid, k == kexp);
            chk_bit("txn_other_rsp", cli ? a_rsp_valid : b_rsp_valid, 1'b0);
            chk_bit("txn_ram_we", ram_we, (k == 1) && we);
            chk_word("txn_ram_addr", 16'(ram_addr), 16'(addr));
            chk_bit("txn_busy", busy, k <= kexp);
            if (k == 1) chk_word("txn_ram_data_in", ram_data_in, wdata);
            if (k == kexp) chk_word("txn_rdata", cli ? b_rsp_rdata : a_rsp_rdata, exp);
            if (k <= kexp) step();
        end
    endtask

    // Client A transaction on dut0 (asynchronous read RAM).
    task automatic l0_txn(input logic we, input logic [8:0] addr,
                          input logic [15:0] wdata, input logic [15:0] exp);
        l0_a_req_valid = 1'b1; l0_a_req_we = we; l0_a_req_addr = addr; l0_a_req_wdata = wdata;
        #1;
        chk_bit("l0_ready", l0_a_req_ready, 1'b1);
        step();
        l0_a_req_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            chk_bit("l0_rsp", l0_a_rsp_valid, k == 2);
            chk_bit("l0_b_rsp", l0_b_rsp_valid, 1'b0);
            chk_bit("l0_ram_we", l0_ram_we, (k == 1) && we);
            chk_bit("l0_busy", l0_busy, k <= 2);
            if (k == 2) chk_word("l0_rdata", l0_a_rsp_rdata, exp);
            if (k <= 2) step();
        end
    endtask

    typedef struct {
        logic        cli;
        logic        we;
        logic [8:0]  addr;
        logic [15:0] wdata;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [7];

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before the test sequence ended");
        $fatal(1, "watchdog");
    end

    initial begin
        int   grants;
        logic exp_cli;

        vecs[0] = '{cli: 1'b0, we: 1'b1, addr: 9'h000, wdata: 16'hA5A5, exp: 16'h0000};
        vecs[1] = '{cli: 1'b0, we: 1'b0, addr: 9'h000, wdata: 16'h0000, exp: 16'hA5A5};
        vecs[2] = '{cli: 1'b1, we: 1'b1, addr: 9'h010, wdata: 16'h1234, exp: 16'h0000};
        vecs[3] = '{cli: 1'b1, we: 1'b0, addr: 9'h010, wdata: 16'h0000, exp: 16'h1234};
        vecs[4] = '{cli: 1'b0, we: 1'b0, addr: 9'h010, wdata: 16'h0000, exp: 16'h1234};
        vecs[5] = '{cli: 1'b1, we: 1'b1, addr: 9'h000, wdata: 16'hBEEF, exp: 16'h0000};
        vecs[6] = '{cli: 1'b0, we: 1'b0, addr: 9'h000, wdata: 16'h0000, exp: 16'hBEEF};

        a_req_valid = 0; a_req_we = 0; a_req_addr = '0; a_req_wdata = '0;
        b_req_valid = 0; b_req_we = 0; b_req_addr = '0; b_req_wdata = '0;
        l0_a_req_valid = 0; l0_a_req_we = 0; l0_a_req_addr = '0; l0_a_req_wdata = '0;
        l0_b_req_valid = 0; l0_b_req_we = 0; l0_b_req_addr = '0; l0_b_req_wdata = '0;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;

        // Reset values
        chk_bit("rst_a_ready", a_req_ready, 1'b0);
        chk_bit("rst_b_ready", b_req_ready, 1'b0);
        chk_bit("rst_a_rsp", a_rsp_valid, 1'b0);
        chk_bit("rst_b_rsp", b_rsp_valid, 1'b0);
        chk_word("rst_a_rdata", a_rsp_rdata, 16'h0000);
        chk_word("rst_b_rdata", b_rsp_rdata, 16'h0000);
        chk_word("rst_ram_addr", 16'(ram_addr), 16'h0000);
        chk_word("rst_ram_data_in", ram_data_in, 16'h0000);
        chk_bit("rst_ram_we", ram_we, 1'b0);
        chk_bit("rst_busy", busy, 1'b0);
        chk_bit("rst_l0_busy", l0_busy, 1'b0);

        // Directed single-client transactions
        for (int i = 0; i < 7; i++) begin
            txn(vecs[i].cli, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp);
        end
        chk_word("hold_a_rdata", a_rsp_rdata, 16'hBEEF);
        chk_word("hold_b_rdata", b_rsp_rdata, 16'h0000);

        // Simultaneous writes from reset: A first, then B
        do_reset();
        a_req_valid = 1; a_req_we = 1; a_req_addr = 9'h001; a_req_wdata = 16'hF0F0;
        b_req_valid = 1; b_req_we = 1; b_req_addr = 9'h1FF; b_req_wdata = 16'h5A5A;
        #1;
        chk_bit("sim_a_ready", a_req_ready, 1'b1);
        chk_bit("sim_b_not_ready", b_req_ready, 1'b0);
        step();
        a_req_valid = 0;
        chk_bit("sim_b_wait1", b_req_ready, 1'b0);
        step();
        chk_bit("sim_a_rsp", a_rsp_valid, 1'b1);
        chk_bit("sim_b_wait2", b_req_ready, 1'b0);
        step();
        chk_bit("sim_b_ready", b_req_ready, 1'b1);
        chk_bit("sim_a_idle", a_rsp_valid, 1'b0);
        step();
        b_req_valid = 0;
        step();
        chk_bit("sim_b_rsp", b_rsp_valid, 1'b1);
        chk_bit("sim_a_rsp_quiet", a_rsp_valid, 1'b0);
        step();
        chk_bit("sim_idle", busy, 1'b0);

        // A alone, so B holds priority for the next tie
        txn(1'b0, 1'b0, 9'h001, 16'h0000, 16'hF0F0);

        // Simultaneous reads of 0x1FF: B first, then A
        a_req_valid = 1; a_req_we = 0; a_req_addr = 9'h1FF; a_req_wdata = '0;
        b_req_valid = 1; b_req_we = 0; b_req_addr = 9'h1FF; b_req_wdata = '0;
        #1;
        chk_bit("rd2_b_ready", b_req_ready, 1'b1);
        chk_bit("rd2_a_not_ready", a_req_ready, 1'b0);
        step();
        b_req_valid = 0;
        step();
        step();
        chk_bit("rd2_b_rsp", b_rsp_valid, 1'b1);
        chk_word("rd2_b_rdata", b_rsp_rdata, 16'h5A5A);
        chk_bit("rd2_a_quiet", a_rsp_valid, 1'b0);
        step();
        chk_bit("rd2_a_ready", a_req_ready, 1'b1);
        step();
        a_req_valid = 0;
        step();
        step();
        chk_bit("rd2_a_rsp", a_rsp_valid, 1'b1);
        chk_word("rd2_a_rdata", a_rsp_rdata, 16'h5A5A);
        chk_bit("rd2_b_quiet", b_rsp_valid, 1'b0);
        step();

        // Both continuously valid: grants alternate A,B,A,B,A,B
        do_reset();
        a_req_valid = 1; a_req_we = 1; a_req_addr = 9'h020; a_req_wdata = 16'h1111;
        b_req_valid = 1; b_req_we = 1; b_req_addr = 9'h021; b_req_wdata = 16'h2222;
        grants  = 0;
        exp_cli = 1'b0;
        for (int c = 0; c < 40 && grants < 6; c++) begin
            #1;
            if (busy) chk_bit("alt_ready_while_busy", a_req_ready | b_req_ready, 1'b0);
            chk_bit("alt_ready_both", a_req_ready & b_req_ready, 1'b0);
            if (a_req_ready | b_req_ready) begin
                chk_bit("alt_order", b_req_ready, exp_cli);
                exp_cli = ~exp_cli;
                grants++;
            end
            @(posedge clk);
        end
        #1;
        a_req_valid = 0;
        b_req_valid = 0;
        chk_word("alt_grants", 16'(grants), 16'd6);
        for (int c = 0; c < 4; c++) step();
        chk_bit("alt_idle", busy, 1'b0);

        // Reset during the WAIT cycle of a B read
        b_req_valid = 1; b_req_we = 0; b_req_addr = 9'h1FF;
        #1;
        chk_bit("rw_b_ready", b_req_ready, 1'b1);
        step();
        b_req_valid = 0;
        step();
        chk_bit("rw_busy_in_wait", busy, 1'b1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_bit("rw_no_rsp", b_rsp_valid, 1'b0);
        chk_bit("rw_idle", busy, 1'b0);
        chk_bit("rw_ram_we", ram_we, 1'b0);
        chk_word("rw_b_rdata", b_rsp_rdata, 16'h0000);
        step();
        chk_bit("rw_no_rsp_late", b_rsp_valid, 1'b0);
        txn(1'b0, 1'b0, 9'h001, 16'h0000, 16'hF0F0);

        // Reset coinciding with a write's ISSUE edge: write still lands
        a_req_valid = 1; a_req_we = 1; a_req_addr = 9'h002; a_req_wdata = 16'h7777;
        #1;
        chk_bit("ri_a_ready", a_req_ready, 1'b1);
        step();
        a_req_valid = 0;
        chk_bit("ri_ram_we_issue", ram_we, 1'b1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_bit("ri_ram_we_after", ram_we, 1'b0);
        chk_bit("ri_no_rsp", a_rsp_valid, 1'b0);
        chk_bit("ri_idle", busy, 1'b0);
        step();
        chk_bit("ri_no_rsp_late", a_rsp_valid, 1'b0);
        txn(1'b0, 1'b0, 9'h002, 16'h0000, 16'h7777);

        // RD_LATENCY=0 instance: write then read back at handshake+2
        l0_txn(1'b1, 9'h1FF, 16'h5A5A, 16'h0000);
        l0_txn(1'b0, 9'h1FF, 16'h0000, 16'h5A5A);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
